// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO with push, pop, flush and occupancy count. Storage resets to RESET_VAL
// so the head reads a defined value straight out of reset.
module fetch_buffer #(
    parameter int unsigned      DEPTH     = 2,
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     CntW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: next-PC selection, credit-limited in-order imem requests, a
// response buffer towards decode and redirect handling that drops stale responses.
// XLEN must match fetch_pkg::XLEN since buffer entries use fetch_entry_t.
module if_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc_plus4_o
);

    import fetch_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] out_cnt, cnt;
    logic [CntW:0]   occupancy;
    logic            fire, pop, push, discard;
    logic [XLEN-1:0] tag_head;
    fetch_entry_t    buf_head, buf_push_data;

    assign pop       = id_valid_o & id_ready_i;
    // Credits: every outstanding request must have a buffer slot once it returns. Popping this
    // cycle frees a slot immediately so a 1-cycle memory sustains full rate.
    assign occupancy = {1'b0, out_cnt} + {1'b0, cnt} - {{CntW{1'b0}}, pop};
    assign imem_req_valid_o = (state_q != BOOT) & ~redirect_i
                              & (occupancy < (CntW + 1)'(DEPTH));
    assign imem_req_addr_o  = pc_i;
    assign fire             = imem_req_valid_o & imem_req_ready_i;

    // Responses from the abandoned path are dropped, including one arriving with the redirect.
    assign discard       = (drop_cnt_q != '0) | redirect_i;
    assign push          = imem_rsp_valid_i & ~discard;
    assign buf_push_data = {tag_head, imem_rsp_data_i};

    assign id_valid_o    = (cnt != '0) & ~redirect_i;
    assign id_instr_o    = buf_head.instr;
    assign id_pc_o       = buf_head.pc;
    assign id_pc_plus4_o = buf_head.pc + XLEN'(4);

    // Next-PC mux; reset term is combinational so the PC register sees RESET_PC immediately.
    always_comb begin
        pc_next_o = pc_i;
        if (!rst_in) begin
            pc_next_o = RESET_PC;
        end else if (redirect_i) begin
            pc_next_o = redirect_pc_i & ~XLEN'(3);
        end else if (fire) begin
            pc_next_o = pc_i + XLEN'(4);
        end
    end

    // FSM next state and drop counter.
    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_i) begin
            drop_cnt_d = out_cnt - CntW'(imem_rsp_valid_i);
        end else if (imem_rsp_valid_i && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
        end
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect_i && drop_cnt_d != '0) state_d = DRAIN;
            DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM and drop counter registers.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= BOOT;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // In-flight PC tags; its occupancy is the outstanding-request count. Never flushed so that
    // dropped responses still retire their tag in order.
    fetch_buffer #(
        .DEPTH     (DEPTH),
        .WIDTH     (XLEN),
        .RESET_VAL ('0)
    ) u_tag_queue (
        .clk         (clk),
        .rst_in      (rst_in),
        .push_i      (fire),
        .push_data_i (pc_i),
        .pop_i       (imem_rsp_valid_i),
        .flush_i     (1'b0),
        .head_o      (tag_head),
        .count_o     (out_cnt)
    );

    // Instruction buffer towards decode.
    fetch_buffer #(
        .DEPTH     (DEPTH),
        .WIDTH     ($bits(fetch_entry_t)),
        .RESET_VAL ({RESET_PC, NOP_INSTR})
    ) u_instr_buf (
        .clk         (clk),
        .rst_in      (rst_in),
        .push_i      (push),
        .push_data_i (buf_push_data),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (buf_head),
        .count_o     (cnt)
    );

    // Memory protocol checks.
    assert property (@(posedge clk) disable iff (!rst_in) imem_rsp_valid_i |-> out_cnt != '0);
    assert property (@(posedge clk) disable iff (!rst_in) out_cnt <= CntW'(DEPTH));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a PC register model and an in-order memory model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_in;
    logic [31:0] pc_i;
    logic [31:0] pc_next_o;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;

    int          n_cmp;
    int          n_err;
    int          n_fire;
    bit          rsp_en;
    logic [31:0] mq[$];

    if_fetch_unit dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .pc_i             (pc_i),
        .pc_next_o        (pc_next_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o),
        .id_pc_plus4_o    (id_pc_plus4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Instruction word the memory returns for an address.
    function automatic logic [31:0] mk(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic refresh_rsp();
        imem_rsp_valid_i = rsp_en && (mq.size() > 0);
        imem_rsp_data_i  = (mq.size() > 0) ? mk(mq[0]) : 32'h0;
    endtask

    // One clock: PC register loads pc_next_o, memory queues accepted requests and retires the
    // response it presented.
    task automatic tick();
        logic        f, rv;
        logic [31:0] a, nxt;
        #1;
        f   = imem_req_valid_o & imem_req_ready_i;
        a   = imem_req_addr_o;
        nxt = pc_next_o;
        rv  = imem_rsp_valid_i;
        @(posedge clk);
        #1;
        if (rv) void'(mq.pop_front());
        if (f) begin
            mq.push_back(a);
            n_fire++;
        end
        pc_i = nxt;
        refresh_rsp();
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reset, release, and step past the BOOT cycle.
    task automatic do_reset();
        rst_in = 1'b0;
        mq.delete();
        pc_i = 32'h0;
        refresh_rsp();
        tick();
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_fire = 0;
        rst_in = 1'b0;
        pc_i = 32'h0;
        imem_req_ready_i = 1'b1;
        rsp_en = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        id_ready_i = 1'b1;
        refresh_rsp();

        // Reset values.
        tick();
        tick();
        chk1("rst_req_valid", imem_req_valid_o, 1'b0);
        chk1("rst_id_valid", id_valid_o, 1'b0);
        chk32("rst_pc_next", pc_next_o, 32'h0);
        chk32("rst_id_instr", id_instr_o, 32'h0000_0013);
        chk32("rst_id_pc", id_pc_o, 32'h0);

        // Release: one BOOT cycle, then streaming with a 1-cycle memory.
        rst_in = 1'b1;
        #1;
        chk1("boot_req_valid", imem_req_valid_o, 1'b0);
        tick();
        chk1("first_req_valid", imem_req_valid_o, 1'b1);
        chk32("first_req_addr", imem_req_addr_o, 32'h0);
        chk32("first_pc_next", pc_next_o, 32'h4);
        tick();
        chk1("fill_id_valid", id_valid_o, 1'b0);
        chk32("second_req_addr", imem_req_addr_o, 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("stream_id_valid", id_valid_o, 1'b1);
            chk32("stream_id_pc", id_pc_o, 32'(i * 4));
            chk32("stream_id_instr", id_instr_o, mk(32'(i * 4)));
            chk32("stream_id_pc_plus4", id_pc_plus4_o, 32'(i * 4 + 4));
        end

        // Decode stalled: only two requests, head stable, resume at 8.
        id_ready_i = 1'b0;
        do_reset();
        n_fire = 0;
        tick();
        tick();
        chk1("stall_req_valid_a", imem_req_valid_o, 1'b0);
        tick();
        tick();
        chk1("stall_req_valid_b", imem_req_valid_o, 1'b0);
        chk1("stall_id_valid", id_valid_o, 1'b1);
        chk32("stall_head_pc", id_pc_o, 32'h0);
        chk32("stall_head_instr", id_instr_o, mk(32'h0));
        chk32("stall_fires", 32'(n_fire), 32'd2);
        id_ready_i = 1'b1;
        #1;
        chk1("resume_req_valid", imem_req_valid_o, 1'b1);
        chk32("resume_req_addr", imem_req_addr_o, 32'h8);
        tick();
        chk32("resume_id_pc", id_pc_o, 32'h4);

        // Redirect with two outstanding and one response in the same cycle.
        rsp_en = 1'b0;
        do_reset();
        tick();
        tick();
        chk1("pre_redir_req_valid", imem_req_valid_o, 1'b0);
        rsp_en = 1'b1;
        refresh_rsp();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        #1;
        chk32("redir_pc_next", pc_next_o, 32'h100);
        chk1("redir_req_valid", imem_req_valid_o, 1'b0);
        chk1("redir_id_valid", id_valid_o, 1'b0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk1("drain_req_valid", imem_req_valid_o, 1'b1);
        chk32("drain_req_addr", imem_req_addr_o, 32'h100);
        chk1("drain_id_valid_a", id_valid_o, 1'b0);
        tick();
        chk1("drain_id_valid_b", id_valid_o, 1'b0);
        tick();
        chk1("target_id_valid", id_valid_o, 1'b1);
        chk32("target_id_pc", id_pc_o, 32'h100);
        chk32("target_id_instr", id_instr_o, mk(32'h100));

        // Misaligned redirect target is forced to word alignment.
        redirect_i = 1'b1;
        redirect_pc_i = 32'h103;
        #1;
        chk32("align_pc_next", pc_next_o, 32'h100);
        tick();
        redirect_i = 1'b0;
        #1;
        chk1("align_req_valid", imem_req_valid_o, 1'b1);
        chk32("align_req_addr", imem_req_addr_o, 32'h100);
        chk1("align_id_valid", id_valid_o, 1'b0);

        // PC wrap at the top of the address space.
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        #1;
        tick();
        redirect_i = 1'b0;
        #1;
        chk32("wrap_req_addr", imem_req_addr_o, 32'hFFFF_FFFC);
        chk32("wrap_pc_next", pc_next_o, 32'h0);
        tick();
        tick();
        chk1("wrap_id_valid", id_valid_o, 1'b1);
        chk32("wrap_id_pc", id_pc_o, 32'hFFFF_FFFC);
        chk32("wrap_id_pc_plus4", id_pc_plus4_o, 32'h0);

        // Asynchronous reset while draining two stale responses.
        rsp_en = 1'b0;
        do_reset();
        tick();
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        #1;
        tick();
        redirect_i = 1'b0;
        #1;
        chk32("drain2_pc_next", pc_next_o, 32'h200);
        rst_in = 1'b0;
        #1;
        chk32("async_pc_next", pc_next_o, 32'h0);
        chk1("async_req_valid", imem_req_valid_o, 1'b0);
        chk1("async_id_valid", id_valid_o, 1'b0);
        chk32("async_id_instr", id_instr_o, 32'h0000_0013);
        chk32("async_id_pc", id_pc_o, 32'h0);
        mq.delete();
        pc_i = 32'h0;
        rsp_en = 1'b1;
        refresh_rsp();
        tick();
        rst_in = 1'b1;
        #1;
        chk1("reboot_boot_req_valid", imem_req_valid_o, 1'b0);
        tick();
        chk1("reboot_req_valid", imem_req_valid_o, 1'b1);
        chk32("reboot_req_addr", imem_req_addr_o, 32'h0);
        tick();
        tick();
        chk1("reboot_id_valid", id_valid_o, 1'b1);
        chk32("reboot_id_pc", id_pc_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage sitting between the program-counter register and the decode stage. It computes the program counter's next value, issues in-order instruction-memory requests with up to two outstanding, and buffers returned instructions with their PCs in a 2-entry queue for decode. Branch/jump redirects flush the queue and discard in-flight responses from the old path.

## Interface
- XLEN, 32: address/data width.
- RESET_PC, 32'h0000_0000: PC value driven during reset; matches the program-counter register's reset value.
- DEPTH, 2: buffer entries, which is also the credit limit on outstanding requests.

- clk  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-low.
- pc_i  in  XLEN  current PC from the program-counter register.
- pc_next_o  out  XLEN  next PC, to the program-counter register.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_addr_o  out  XLEN  fetch address, equal to pc_i.
- imem_req_ready_i  in  1  memory accepts the request this cycle.
- imem_rsp_valid_i  in  1  instruction returned, in request order.
- imem_rsp_data_i  in  32  instruction word.
- redirect_i  in  1  taken branch/jump from EX.
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] are forced to 0.
- id_valid_o  out  1  decode-side entry valid.
- id_ready_i  in  1  decode accepts the entry.
- id_instr_o  out  32  instruction at buffer head.
- id_pc_o  out  XLEN  PC of that instruction.
- id_pc_plus4_o  out  XLEN  id_pc_o + 4, modulo 2^XLEN.

## Operation
- FSM states: BOOT, RUN, DRAIN.
  - Reset enters BOOT.
  - BOOT lasts exactly one cycle after rst_in deasserts, then moves to RUN. It gives the PC register's synchronous reset time to settle.
  - RUN moves to DRAIN when a redirect leaves drop_cnt_next > 0.
  - DRAIN moves to RUN when drop_cnt reaches 0.
- Counters:
  - out_cnt: outstanding requests, 0..DEPTH.
  - cnt: buffer occupancy, 0..DEPTH.
  - drop_cnt: responses still to discard, 0..DEPTH.
- Request issue: fire = imem_req_valid_o & imem_req_ready_i.
  - imem_req_valid_o = state!=BOOT & ~redirect_i & (out_cnt + cnt − pop < DEPTH).
  - pop = id_valid_o & id_ready_i.
  - Requests are issued in RUN and in DRAIN.
- Next-PC mux, in priority order:
  - rst_in low: RESET_PC.
  - redirect_i: {redirect_pc_i[XLEN-1:2], 2'b00}.
  - fire: pc_i + 4, wrapping at 2^XLEN.
  - otherwise: pc_i.
- The PC of each request is held in a DEPTH-entry in-flight tag queue.
- Response handling:
  - If drop_cnt > 0 or redirect_i is high, the response is discarded and drop_cnt decrements.
  - Otherwise the response is written to the buffer together with its tagged PC.
  - Every response retires one out_cnt.
- Redirect cycle:
  - The buffer is cleared.
  - drop_cnt_next = out_cnt − imem_rsp_valid_i.
  - No request is issued.
  - id_valid_o is forced to 0.
- id_valid_o = cnt != 0 & ~redirect_i. Buffer head fields are stable while id_valid_o is high and id_ready_i is low.
- A simultaneous push and pop with cnt = DEPTH cannot occur: credits guarantee space for every accepted response.
- Protocol assertions:
  - imem_rsp_valid_i with out_cnt = 0 is an error.
  - out_cnt > DEPTH is an error.

## Timing
- Reset values:
  - state = BOOT; out_cnt = cnt = drop_cnt = 0.
  - imem_req_valid_o = 0, id_valid_o = 0, pc_next_o = RESET_PC.
  - id_instr_o = 32'h0000_0013 (NOP); id_pc_o = RESET_PC.
- Latency:
  - Request accepted at cycle t.
  - Response earliest at t+1.
  - Entry presented to decode on the cycle after the response.
- Throughput: 1 instruction/cycle with a 1-cycle memory and id_ready_i held high. This relies on pop being credited in the same cycle, so there is a combinational path from id_ready_i to imem_req_valid_o.
- Redirect at cycle t: the first request to the target issues at t+1, with pc_i = target.
- Reset mid-operation: all state clears immediately. Responses arriving after reset are the memory's responsibility; the memory is reset from the same rst_in.

## Structure
- Package fetch_pkg holds:
  - XLEN, ILEN = 32, NOP_INSTR = 32'h0000_0013.
  - The fetch_state_e enum {BOOT, RUN, DRAIN}.
  - The fetch_entry_t struct {pc, instr}.
- Sub-module fetch_buffer: DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count. It is instantiated twice: once as the instruction buffer, once (pc only) as the in-flight tag queue.

## Test plan
- Reset release, 1-cycle memory, id_ready_i = 1:
  - First request is at addr 0 on the second cycle after release.
  - Decode sees PCs 0, 4, 8, 12 on consecutive cycles.
- id_ready_i held low:
  - At most 2 requests are issued (addr 0, 4) and then imem_req_valid_o stays 0.
  - Buffer head holds PC 0 and is stable.
  - Raising id_ready_i resumes at addr 8.
- Redirect to 0x100 with 2 outstanding, one response arriving in the same cycle:
  - Both old responses are discarded.
  - pc_next_o = 0x100.
  - The first instruction delivered to decode has PC 0x100.
- redirect_pc_i = 0x103: fetch address becomes 0x100.
- pc_i = 0xFFFF_FFFC with fire: pc_next_o = 0 and id_pc_plus4_o = 0.
- rst_in pulsed low while DRAIN has drop_cnt = 2:
  - All outputs return to reset values asynchronously.
  - BOOT repeats, then fetch restarts at RESET_PC.
